// File: rtl/program_loader.sv
// Program loader: streams host words into program memory, optionally
// re-reads them for an XOR checksum, then loads the PC and releases fetch.
module program_loader #(
    parameter int INST_W = 67,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              pm_wr,
    output logic              pm_rd,
    output logic [ADDR_W-1:0] pm_address,
    output logic [INST_W-1:0] pm_inst_out,
    output logic              pm_inst_oe,
    input  logic [INST_W-1:0] pm_inst_in,
    output logic              fetch_hold,
    output logic              pc_load_wr,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_W:0] L_DEPTH = DEPTH[ADDR_W:0];

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     r_acc;
    logic [ADDR_W:0]     r_rdi;
    logic [INST_W-1:0]   r_wsum;
    logic [INST_W-1:0]   r_rsum;
    logic [INST_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic                r_rd;
    logic                r_rd_d;
    logic                r_hold;
    logic                r_pcwr;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_cnt_ok;
    logic                w_wr_last;
    logic                w_mis;
    logic [INST_W-1:0]   w_rsum_fin;

    assign in_ready   = (r_state == S_WRITE) && (r_acc < r_cnt);
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_ok   = (load_count != '0) && (load_count <= L_DEPTH);
    assign w_wr_last  = r_wr && (r_acc == r_cnt);

    // The last read word arrives during RELEASE, so fold it in here.
    assign w_rsum_fin = r_rd_d ? (r_rsum ^ pm_inst_in) : r_rsum;
    assign w_mis      = (VERIFY != 0) && (r_state == S_RELEASE)
                        && (w_rsum_fin != r_wsum);

    assign pm_wr        = r_wr;
    assign pm_inst_oe   = r_wr;
    assign pm_rd        = r_rd;
    assign pm_address   = r_addr;
    assign pm_inst_out  = r_data;
    assign fetch_hold   = r_hold;
    assign pc_load_wr   = r_pcwr;
    assign pc_load_addr = r_base;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign error        = r_err | w_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rdi   <= '0;
            r_wsum  <= '0;
            r_rsum  <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_rd_d  <= 1'b0;
            r_hold  <= 1'b0;
            r_pcwr  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
            r_pcwr <= 1'b0;
            r_done <= 1'b0;
            r_rd_d <= r_rd;
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        if (w_cnt_ok) begin
                            r_base  <= load_base;
                            r_cnt   <= load_count;
                            r_acc   <= '0;
                            r_rdi   <= '0;
                            r_wsum  <= '0;
                            r_rsum  <= '0;
                            r_err   <= 1'b0;
                            r_hold  <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_wr   <= 1'b1;
                        r_addr <= r_base + r_acc[ADDR_W-1:0];
                        r_data <= in_inst;
                        r_wsum <= r_wsum ^ in_inst;
                        r_acc  <= r_acc + 1'b1;
                    end
                    if (w_wr_last) begin
                        if (VERIFY != 0) begin
                            r_rd    <= 1'b1;
                            r_addr  <= r_base;
                            r_rdi   <= {{ADDR_W{1'b0}}, 1'b1};
                            r_state <= S_VERIFY;
                        end else begin
                            r_pcwr  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_VERIFY: begin
                    if (r_rd_d) begin
                        r_rsum <= r_rsum ^ pm_inst_in;
                    end
                    if (r_rdi < r_cnt) begin
                        r_rd   <= 1'b1;
                        r_addr <= r_base + r_rdi[ADDR_W-1:0];
                        r_rdi  <= r_rdi + 1'b1;
                    end else begin
                        r_pcwr  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_rsum  <= w_rsum_fin;
                    r_hold  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_mis) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
